// File: rtl/rob_ram_pkg.sv
// Shared constants and helpers for the multi-port reorder-buffer RAM.
// Read-mode selectors and a packed-bus field extractor used by the top and read ports.
package rob_ram_pkg;

  localparam int RD_COMB   = 0;
  localparam int RD_REGD   = 1;

  // Upper bounds for the generic field extractor below.
  localparam int BUS_MAX   = 512;
  localparam int FIELD_MAX = 64;

  function automatic logic [FIELD_MAX-1:0] unpack_port(
    input logic [BUS_MAX-1:0] bus,
    input int                 k,
    input int                 w
  );
    logic [BUS_MAX-1:0] shifted;
    logic [BUS_MAX-1:0] mask;
    shifted = bus >> (k * w);
    mask    = (BUS_MAX'(1'b1) << w) - BUS_MAX'(1'b1);
    return FIELD_MAX'(shifted & mask);
  endfunction

endpackage

// File: rtl/rob_ram_rd_port.sv
// One read port of the ROB RAM: range check, write-bypass select and
// optional output register.
module rob_ram_rd_port
  import rob_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR   = 4,
  parameter int DEPTH  = 16,
  parameter int RD_REG = RD_REGD,
  parameter int BYPASS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_en_i,
  input  logic [ADDR-1:0]  rd_addr_i,
  input  logic [WIDTH-1:0] ent_data_i,
  input  logic             ent_vld_i,
  input  logic             byp_hit_i,
  input  logic [WIDTH-1:0] byp_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_vld_o,
  output logic             rd_ack_o
);

  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic             in_range_s;
  logic             byp_s;
  logic [WIDTH-1:0] res_data_s;
  logic             res_vld_s;

  assign in_range_s = ({1'b0, rd_addr_i} < DEPTH_W);
  assign byp_s      = (BYPASS != 0) ? byp_hit_i : 1'b0;

  // Resolve the value this port would return: out-of-range, bypassed or stored.
  always_comb begin
    res_data_s = '0;
    res_vld_s  = 1'b0;
    if (!in_range_s) begin
      res_data_s = '0;
      res_vld_s  = 1'b0;
    end else if (byp_s) begin
      res_data_s = byp_data_i;
      res_vld_s  = 1'b1;
    end else begin
      res_data_s = ent_data_i;
      res_vld_s  = ent_vld_i;
    end
  end

  generate
    if (RD_REG == RD_REGD) begin : g_regd
      logic [WIDTH-1:0] data_q, data_d;
      logic             vld_q, vld_d;
      logic             ack_q, ack_d;

      // Next-state for the output register; a disabled port keeps its data.
      always_comb begin
        data_d = data_q;
        vld_d  = 1'b0;
        ack_d  = rd_en_i;
        if (rd_en_i) begin
          data_d = res_data_s;
          vld_d  = res_vld_s;
        end else begin
          data_d = data_q;
          vld_d  = 1'b0;
        end
      end

      // Output register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          data_q <= '0;
          vld_q  <= 1'b0;
          ack_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          vld_q  <= vld_d;
          ack_q  <= ack_d;
        end
      end

      assign rd_data_o = data_q;
      assign rd_vld_o  = vld_q;
      assign rd_ack_o  = ack_q;
    end else begin : g_comb
      // Combinational result, forced to zero while disabled or held in reset.
      always_comb begin
        rd_data_o = '0;
        rd_vld_o  = 1'b0;
        rd_ack_o  = rd_en_i & ~rst_i;
        if (rst_i || !rd_en_i) begin
          rd_data_o = '0;
          rd_vld_o  = 1'b0;
        end else begin
          rd_data_o = res_data_s;
          rd_vld_o  = res_vld_s;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rob_mp_ram.sv
// Multi-port ROB storage: NWR writers, NRD readers, per-entry valid bits,
// invalidate/flush and optional write-to-read bypass.
module rob_mp_ram
  import rob_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR   = 4,
  parameter int DEPTH  = 32'd1 << ADDR,
  parameter int NWR    = 2,
  parameter int NRD    = 3,
  parameter int RD_REG = RD_REGD,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ADDR-1:0]  wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 inv_en,
  input  logic [ADDR-1:0]      inv_addr,
  input  logic                 flush,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*ADDR-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_vld,
  output logic [NRD-1:0]       rd_ack,
  output logic                 wr_collide
);

  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic [ADDR-1:0]  wa_s [NWR];
  logic [WIDTH-1:0] wd_s [NWR];
  logic [NWR-1:0]   wv_s;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             collide_q, collide_d;

  logic [ADDR-1:0]  ra_s       [NRD];
  logic [WIDTH-1:0] ent_data_s [NRD];
  logic [NRD-1:0]   ent_vld_s;
  logic [NRD-1:0]   byp_hit_s;
  logic [WIDTH-1:0] byp_data_s [NRD];

  // Unpack write ports; a port only counts when enabled and in range.
  always_comb begin : p_wr_unpack
    wv_s = '0;
    for (int k = 0; k < NWR; k++) begin
      wa_s[k] = ADDR'(unpack_port(BUS_MAX'(wr_addr), k, ADDR));
      wd_s[k] = WIDTH'(unpack_port(BUS_MAX'(wr_data), k, WIDTH));
      wv_s[k] = wr_en[k] & ({1'b0, wa_s[k]} < DEPTH_W);
    end
  end

  // Any pair of live write ports on the same entry is a collision.
  always_comb begin : p_collide
    collide_d = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      for (int m = k + 1; m < NWR; m++) begin
        collide_d = collide_d | (wv_s[k] & wv_s[m] & (wa_s[k] == wa_s[m]));
      end
    end
  end

  // Per-entry next state: later ports override earlier ones, and a write
  // beats a same-cycle flush or invalidate.
  always_comb begin : p_wr_resolve
    logic             hit_s;
    logic             clr_s;
    logic             sel_s;
    logic [WIDTH-1:0] wdat_s;
    hit_s   = 1'b0;
    clr_s   = 1'b0;
    sel_s   = 1'b0;
    wdat_s  = '0;
    valid_d = valid_q;
    for (int e = 0; e < DEPTH; e++) begin
      hit_s  = 1'b0;
      wdat_s = mem_q[e];
      for (int k = 0; k < NWR; k++) begin
        sel_s  = wv_s[k] & (wa_s[k] == ADDR'(e));
        wdat_s = sel_s ? wd_s[k] : wdat_s;
        hit_s  = hit_s | sel_s;
      end
      clr_s      = flush | (inv_en & (inv_addr == ADDR'(e)));
      mem_d[e]   = wdat_s;
      valid_d[e] = hit_s | (valid_q[e] & ~clr_s);
    end
  end

  // Per read port: stored entry lookup plus the winning same-cycle write.
  always_comb begin : p_rd_lookup
    logic             sel_s;
    logic [WIDTH-1:0] d_s;
    logic             v_s;
    logic             h_s;
    logic [WIDTH-1:0] b_s;
    sel_s     = 1'b0;
    d_s       = '0;
    v_s       = 1'b0;
    h_s       = 1'b0;
    b_s       = '0;
    ent_vld_s = '0;
    byp_hit_s = '0;
    for (int j = 0; j < NRD; j++) begin
      ra_s[j] = ADDR'(unpack_port(BUS_MAX'(rd_addr), j, ADDR));
      d_s     = '0;
      v_s     = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        sel_s = (ra_s[j] == ADDR'(e));
        d_s   = sel_s ? mem_q[e] : d_s;
        v_s   = sel_s ? valid_q[e] : v_s;
      end
      h_s = 1'b0;
      b_s = '0;
      for (int k = 0; k < NWR; k++) begin
        sel_s = wv_s[k] & (wa_s[k] == ra_s[j]);
        b_s   = sel_s ? wd_s[k] : b_s;
        h_s   = h_s | sel_s;
      end
      ent_data_s[j] = d_s;
      ent_vld_s[j]  = v_s;
      byp_hit_s[j]  = h_s;
      byp_data_s[j] = b_s;
    end
  end

  // Storage, valid bits and the collision flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      valid_q   <= '0;
      collide_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      collide_q <= collide_d;
    end
  end

  assign wr_collide = collide_q;

  generate
    for (genvar j = 0; j < NRD; j++) begin : g_rd
      rob_ram_rd_port #(
        .WIDTH  (WIDTH),
        .ADDR   (ADDR),
        .DEPTH  (DEPTH),
        .RD_REG (RD_REG),
        .BYPASS (BYPASS)
      ) u_rd_port (
        .clk_i      (clk),
        .rst_i      (reset),
        .rd_en_i    (rd_en[j]),
        .rd_addr_i  (ra_s[j]),
        .ent_data_i (ent_data_s[j]),
        .ent_vld_i  (ent_vld_s[j]),
        .byp_hit_i  (byp_hit_s[j]),
        .byp_data_i (byp_data_s[j]),
        .rd_data_o  (rd_data[j*WIDTH +: WIDTH]),
        .rd_vld_o   (rd_vld[j]),
        .rd_ack_o   (rd_ack[j])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rob_mp_ram.sv
// Bench for rob_mp_ram: a registered/bypass instance and a combinational/no-bypass
// instance, both DEPTH=12, driven by a directed table and random traffic.
module tb_rob_mp_ram;

  localparam int WIDTH = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 12;
  localparam int NWR   = 2;
  localparam int NRD   = 3;

  logic                 clk;
  logic                 reset;
  logic [NWR-1:0]       wr_en;
  logic [NWR*ADDR-1:0]  wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 inv_en;
  logic [ADDR-1:0]      inv_addr;
  logic                 flush;
  logic [NRD-1:0]       rd_en;
  logic [NRD*ADDR-1:0]  rd_addr;

  logic [NRD*WIDTH-1:0] r_data, c_data;
  logic [NRD-1:0]       r_vld, r_ack, c_vld, c_ack;
  logic                 r_col, c_col;

  int checks = 0;
  int errors = 0;

  // Reference state: entry contents/valid and the registered port's held data.
  logic [WIDTH-1:0] m_mem  [16];
  logic             m_vld  [16];
  logic [WIDTH-1:0] m_hold [NRD];

  typedef struct {
    logic [NWR-1:0]       wr_en;
    logic [NWR*ADDR-1:0]  wr_addr;
    logic [NWR*WIDTH-1:0] wr_data;
    logic                 inv_en;
    logic [ADDR-1:0]      inv_addr;
    logic                 flush;
    logic [NRD-1:0]       rd_en;
    logic [NRD*ADDR-1:0]  rd_addr;
    logic [NRD*WIDTH-1:0] e_data;
    logic [NRD-1:0]       e_vld;
    logic [NRD-1:0]       e_ack;
    logic                 e_col;
  } vec_t;

  vec_t tbl [11];

  rob_mp_ram #(
    .WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .NWR(NWR), .NRD(NRD),
    .RD_REG(1), .BYPASS(1)
  ) u_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(r_data), .rd_vld(r_vld), .rd_ack(r_ack), .wr_collide(r_col)
  );

  rob_mp_ram #(
    .WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .NWR(NWR), .NRD(NRD),
    .RD_REG(0), .BYPASS(0)
  ) u_comb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(c_data), .rd_vld(c_vld), .rd_ack(c_ack), .wr_collide(c_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 1'b0;
    end
    for (int j = 0; j < NRD; j++) m_hold[j] = '0;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
    rd_en = '0; rd_addr = '0;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic run_cycle();
    logic [NRD*WIDTH-1:0] e_rdata, e_cdata;
    logic [NRD-1:0]       e_rvld, e_cvld, en_s;
    logic                 e_col, hit;
    logic [WIDTH-1:0]     hd;
    int                   a, wa, wb;
    #1;
    en_s  = rd_en;
    e_col = 1'b0;
    for (int k = 0; k < NWR; k++)
      for (int m = k + 1; m < NWR; m++) begin
        wa = int'(wr_addr[k*ADDR +: ADDR]);
        wb = int'(wr_addr[m*ADDR +: ADDR]);
        if (wr_en[k] && wr_en[m] && wa == wb && wa < DEPTH) e_col = 1'b1;
      end
    e_rdata = '0; e_cdata = '0; e_rvld = '0; e_cvld = '0;
    for (int j = 0; j < NRD; j++) begin
      a = int'(rd_addr[j*ADDR +: ADDR]);
      if (rd_en[j] && a < DEPTH) begin
        e_cdata[j*WIDTH +: WIDTH] = m_mem[a];
        e_cvld[j] = m_vld[a];
      end
      hit = 1'b0; hd = '0;
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && int'(wr_addr[k*ADDR +: ADDR]) == a) begin
          hit = 1'b1;
          hd  = wr_data[k*WIDTH +: WIDTH];
        end
      if (rd_en[j]) begin
        if (a >= DEPTH) begin m_hold[j] = '0; e_rvld[j] = 1'b0; end
        else if (hit) begin m_hold[j] = hd; e_rvld[j] = 1'b1; end
        else begin m_hold[j] = m_mem[a]; e_rvld[j] = m_vld[a]; end
      end
      e_rdata[j*WIDTH +: WIDTH] = m_hold[j];
    end
    chk("comb_data", 32'(c_data), 32'(e_cdata));
    chk("comb_vld",  32'(c_vld),  32'(e_cvld));
    chk("comb_ack",  32'(c_ack),  32'(en_s));
    if (flush) for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    if (inv_en && int'(inv_addr) < DEPTH) m_vld[inv_addr] = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      wa = int'(wr_addr[k*ADDR +: ADDR]);
      if (wr_en[k] && wa < DEPTH) begin
        m_mem[wa] = wr_data[k*WIDTH +: WIDTH];
        m_vld[wa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("reg_data", 32'(r_data), 32'(e_rdata));
    chk("reg_vld",  32'(r_vld),  32'(e_rvld));
    chk("reg_ack",  32'(r_ack),  32'(en_s));
    chk("reg_col",  32'(r_col),  32'(e_col));
    chk("comb_col", 32'(c_col),  32'(e_col));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_r_data"}, 32'(r_data), 32'h0);
    chk({tag, "_r_vld"},  32'(r_vld),  32'h0);
    chk({tag, "_r_ack"},  32'(r_ack),  32'h0);
    chk({tag, "_r_col"},  32'(r_col),  32'h0);
    chk({tag, "_c_data"}, 32'(c_data), 32'h0);
    chk({tag, "_c_vld"},  32'(c_vld),  32'h0);
    chk({tag, "_c_ack"},  32'(c_ack),  32'h0);
    chk({tag, "_c_col"},  32'(c_col),  32'h0);
  endtask

  initial begin
    //                wr_en  wr_addr wr_data   inv   iaddr flush rd_en  rd_addr  e_data        e_vld  e_ack  col
    tbl[0]  = '{2'b01, 8'h03, 16'h00A5, 1'b0, 4'h0, 1'b0, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 4'h0, 1'b0, 3'b111, 12'hE43, 24'h0000A5, 3'b001, 3'b111, 1'b0};
    tbl[2]  = '{2'b11, 8'h77, 16'h2211, 1'b0, 4'h0, 1'b0, 3'b000, 12'h000, 24'h0000A5, 3'b000, 3'b000, 1'b1};
    tbl[3]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 4'h0, 1'b0, 3'b010, 12'h070, 24'h0022A5, 3'b010, 3'b010, 1'b0};
    tbl[4]  = '{2'b10, 8'h20, 16'h5C00, 1'b0, 4'h0, 1'b0, 3'b100, 12'h200, 24'h5C22A5, 3'b100, 3'b100, 1'b0};
    tbl[5]  = '{2'b01, 8'h04, 16'h0033, 1'b0, 4'h0, 1'b1, 3'b001, 12'h003, 24'h5C22A5, 3'b001, 3'b001, 1'b0};
    tbl[6]  = '{2'b01, 8'h05, 16'h0044, 1'b1, 4'h4, 1'b0, 3'b011, 12'h034, 24'h5CA533, 3'b001, 3'b011, 1'b0};
    tbl[7]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 4'h0, 1'b0, 3'b111, 12'h254, 24'h5C4433, 3'b010, 3'b111, 1'b0};
    tbl[8]  = '{2'b11, 8'hBE, 16'h6677, 1'b0, 4'h0, 1'b0, 3'b000, 12'h000, 24'h5C4433, 3'b000, 3'b000, 1'b0};
    tbl[9]  = '{2'b00, 8'h00, 16'h0000, 1'b0, 4'h0, 1'b0, 3'b111, 12'hEBE, 24'h006600, 3'b010, 3'b111, 1'b0};
    tbl[10] = '{2'b11, 8'hFF, 16'h9988, 1'b0, 4'h0, 1'b0, 3'b000, 12'h000, 24'h006600, 3'b000, 3'b000, 1'b0};

    idle();
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("rst0");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].wr_en;   wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      inv_en = tbl[i].inv_en; inv_addr = tbl[i].inv_addr; flush = tbl[i].flush;
      rd_en = tbl[i].rd_en;   rd_addr = tbl[i].rd_addr;
      run_cycle();
      chk($sformatf("tbl%0d_data", i), 32'(r_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_vld", i),  32'(r_vld),  32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_ack", i),  32'(r_ack),  32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_col", i),  32'(r_col),  32'(tbl[i].e_col));
    end

    for (int n = 0; n < 300; n++) begin
      wr_en    = NWR'($urandom_range(0, 3));
      wr_addr  = NWR*ADDR'($urandom);
      if ($urandom_range(0, 3) == 0) wr_addr[ADDR +: ADDR] = wr_addr[0 +: ADDR];
      wr_data  = NWR*WIDTH'($urandom);
      inv_en   = ($urandom_range(0, 7) == 0);
      inv_addr = ADDR'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      rd_en    = NRD'($urandom);
      rd_addr  = NRD*ADDR'($urandom);
      run_cycle();
    end

    // Reset asserted between edges while reads and writes are active.
    wr_en = 2'b11; wr_addr = 8'h21; wr_data = 16'hBEEF;
    rd_en = 3'b111; rd_addr = 12'h321;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    wr_en = '0;
    check_all_zero("rst_hold");
    reset = 1'b0;
    model_clear();
    rd_en = 3'b111; rd_addr = 12'hB73;
    run_cycle();
    chk("post_rst_data", 32'(r_data), 32'h0);
    chk("post_rst_vld",  32'(r_vld),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
